uart_pixel_loader: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/rx_timeout_timer.sv | 30 +++
 rtl/uart_pixel_loader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART pixel loader: FSM state codes, header bytes,
// pixel range and the inter-byte timeout derived from the link rate.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam logic [7:0] SYNC0_DEF = 8'hAA;
    localparam logic [7:0] SYNC1_DEF = 8'h55;
    localparam logic [2:0] PIX_MAX   = 3'd7;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115200;

    // Four 8N2 byte times (11 bits each), rounded up to a whole 1000 clocks.
    localparam int BYTE_CYC        = 11 * (CLK_HZ / BAUD);
    localparam int TIMEOUT_CYC_DEF = ((4 * BYTE_CYC + 999) / 1000) * 1000;

    // Bytes above the pixel range saturate to the brightest level.
    function automatic logic [2:0] clamp_pixel(input logic [7:0] b);
        return (b > 8'(PIX_MAX)) ? PIX_MAX : b[2:0];
    endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte watchdog: counts idle clocks while enabled, restarts on every kick,
// and flags expiry on the clock where the count reaches TIMEOUT_CYC-1.
module rx_timeout_timer #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || !enable || kick) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + CNT_W'(1);
        end
    end

    // A byte arriving on the final clock wins over the expiry.
    assign expired = enable && !kick && (count == LAST);

endmodule

// File: rtl/uart_pixel_loader.sv
// Frame loader behind uart_rx: waits for a two-byte sync header, then writes one
// 3-bit pixel per received byte into the frame buffer, aborting on errors or stalls.
module uart_pixel_loader
    import uart_pkg::*;
#(
    parameter int          IMG_W       = 160,
    parameter int          IMG_H       = 120,
    parameter int          ADDR_W      = 15,
    parameter logic [7:0]  SYNC0       = SYNC0_DEF,
    parameter logic [7:0]  SYNC1       = SYNC1_DEF,
    parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_frame_error,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              frame_done,
    output logic              abort,
    output logic              busy,
    output logic [7:0]        err_count,
    output logic [1:0]        state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_d, frame_done_d, abort_d, err_inc;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [2:0]        wr_data_d;
    logic              timeout_expired;

    rx_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (state_q == ST_LOAD),
        .kick    (rx_valid),
        .expired (timeout_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        addr_d       = addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        frame_done_d = 1'b0;
        abort_d      = 1'b0;
        err_inc      = 1'b0;

        if (rx_frame_error) begin
            // A frame error outranks a coincident byte strobe; the byte is dropped.
            err_inc = 1'b1;
            abort_d = (state_q == ST_LOAD);
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && rx_data == SYNC0) state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (rx_valid) begin
                        if (rx_data == SYNC1) begin
                            state_d = ST_LOAD;
                            addr_d  = '0;
                        end else if (rx_data != SYNC0) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (rx_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = clamp_pixel(rx_data);
                        err_inc   = (rx_data > 8'(PIX_MAX));
                        if (addr_q == LAST_ADDR) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end else if (timeout_expired) begin
                        abort_d = 1'b1;
                        err_inc = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            abort      <= 1'b0;
            err_count  <= '0;
        end else begin
            addr_q     <= addr_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            frame_done <= frame_done_d;
            abort      <= abort_d;
            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign state = state_q;

endmodule
